// File: rtl/mem_access_ctrl.sv
// Load/store controller: byte/half/word accesses, sub-word stores via read-modify-write,
// loads aligned and sign/zero-extended. Latency 1-3 cycles to done; ready=0 while busy.
module mem_access_ctrl (
  input  logic        clk_dm,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] DM_Addr,
  output logic [31:0] M_W_Data,
  output logic        Mem_Write,
  input  logic [31:0] M_R_Data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        we_q, sx_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [15:0] wdata_q;
  logic        accept, bad_access;
  logic [31:0] merged, load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign ready     = (state == IDLE) & ~rst;
  assign done      = (state == DONE);
  assign err       = done & err_q;
  assign Mem_Write = (state == WRITE) & ~rst;
  assign accept    = ready & req;

  assign bad_access = (size == 2'b11) |
                      ((size == 2'b01) & addr[0]) |
                      ((size == 2'b10) & (addr[1:0] != 2'b00));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_access)                 state_nxt = DONE;
          else if (we && size == 2'b10)   state_nxt = WRITE;
          else                            state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane select shared by the store merge and the load extract.
  always_comb begin
    byte_sel = M_R_Data[{lane_q, 3'b000} +: 8];
    half_sel = M_R_Data[{lane_q[1], 4'b0000} +: 16];
    merged   = M_R_Data;
    load_val = M_R_Data;
    case (size_q)
      2'b00: begin
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        load_val = {{24{sx_q & byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        load_val = {{16{sx_q & half_sel[15]}}, half_sel};
      end
      default: begin
        merged   = M_R_Data;
        load_val = M_R_Data;
      end
    endcase
  end

  always_ff @(posedge clk_dm) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      sx_q     <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      wdata_q  <= 16'h0;
      rdata    <= 32'h0;
      DM_Addr  <= 32'h0;
      M_W_Data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= we;
        sx_q    <= sign_ext;
        size_q  <= size;
        lane_q  <= addr[1:0];
        wdata_q <= wdata[15:0];
        err_q   <= bad_access;
        DM_Addr <= {addr[31:2], 2'b00};
        if (we && size == 2'b10 && !bad_access)
          M_W_Data <= wdata;
      end
      if (state == READ) begin
        if (we_q) M_W_Data <= merged;
        else      rdata    <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a behavioural data memory plus a scoreboard
// checked by an independent monitor on each done pulse.
module tb_mem_access_ctrl;

  logic        clk_dm = 1'b0;
  logic        rst, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err, Mem_Write;
  logic [31:0] rdata, DM_Addr, M_W_Data, M_R_Data;

  logic [31:0] mem [0:63];
  logic        mem_clr;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic        e;
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  mem_access_ctrl dut (
    .clk_dm(clk_dm), .rst(rst), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .err(err), .rdata(rdata), .DM_Addr(DM_Addr),
    .M_W_Data(M_W_Data), .Mem_Write(Mem_Write), .M_R_Data(M_R_Data)
  );

  always #5 clk_dm = ~clk_dm;

  assign M_R_Data = mem[DM_Addr[7:2]];

  always @(posedge clk_dm) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (Mem_Write) begin
      mem[DM_Addr[7:2]] <= M_W_Data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk_dm) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending access");
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("done_err", {31'b0, err}, {31'b0, x.e});
        check("done_rdata", rdata, x.rd);
        check("done_latency", cyc - x.acc + 1, x.lat);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_dm);
      if (ready) return;
    end
    check("ready_timeout", {31'b0, ready}, 32'h1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_dm);
      if (ready && sb.size() == 0) return;
    end
    check("idle_timeout", sb.size(), 0);
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd, input int e_lat);
    exp_t x;
    wait_ready();
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    x.e = e_err; x.rd = e_rd; x.lat = e_lat; x.acc = cyc + 1;
    sb.push_back(x);
    @(posedge clk_dm);
    #1;
    req = 1'b0;
    addr = ~a; wdata = ~d; size = ~sz; sign_ext = ~sx; we = ~w;
    wait_idle();
  endtask

  int w0;

  initial begin
    exp_t x;
    rst = 1'b1; mem_clr = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
    sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk_dm);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_addr", DM_Addr, 32'h0);
    check("rst_wdata", M_W_Data, 32'h0);
    check("rst_mem_write", {31'b0, Mem_Write}, 32'h0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk_dm);
    check("ready_after_rst", {31'b0, ready}, 32'h1);

    // Reset asserted in the WRITE cycle of a word store must abort the commit.
    w0 = wr_cnt;
    we = 1'b1; size = 2'b10; addr = 32'h10; wdata = 32'hDEADBEEF; req = 1'b1;
    @(posedge clk_dm);
    #1 req = 1'b0;
    @(negedge clk_dm);
    rst = 1'b1;
    #1 check("abort_mem_write", {31'b0, Mem_Write}, 32'h0);
    @(negedge clk_dm);
    check("abort_dm_addr", DM_Addr, 32'h0);
    check("abort_ready_in_rst", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk_dm);
    check("abort_ready_after", {31'b0, ready}, 32'h1);
    check("abort_mem", mem[4], 32'h0);
    check("abort_wr_cnt", wr_cnt - w0, 0);

    w0 = wr_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0, 32'h0, 2);
    check("sw_mem", mem[8], 32'h12345678);
    check("sw_wr_cnt", wr_cnt - w0, 1);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678, 2);

    w0 = wr_cnt;
    access(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFFFFAB, 1'b0, 32'h12345678, 3);
    check("sb_mem", mem[8], 32'h12AB5678);
    check("sb_wr_cnt", wr_cnt - w0, 1);

    access(1'b1, 2'b10, 1'b0, 32'h24, 32'h80FF7F01, 1'b0, 32'h12345678, 2);
    access(1'b0, 2'b00, 1'b1, 32'h26, 32'h0, 1'b0, 32'hFFFFFFFF, 2);
    access(1'b0, 2'b00, 1'b0, 32'h27, 32'h0, 1'b0, 32'h00000080, 2);
    access(1'b0, 2'b01, 1'b1, 32'h26, 32'h0, 1'b0, 32'hFFFF80FF, 2);
    access(1'b0, 2'b01, 1'b0, 32'h24, 32'h0, 1'b0, 32'h00007F01, 2);
    access(1'b0, 2'b00, 1'b1, 32'h24, 32'h0, 1'b0, 32'h00000001, 2);

    w0 = wr_cnt;
    access(1'b1, 2'b01, 1'b0, 32'h26, 32'h1234BEEF, 1'b0, 32'h00000001, 3);
    check("sh_mem", mem[9], 32'hBEEF7F01);
    check("sh_wr_cnt", wr_cnt - w0, 1);

    w0 = wr_cnt;
    access(1'b1, 2'b10, 1'b0, 32'h21, 32'hCAFEF00D, 1'b1, 32'h00000001, 1);
    access(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, 1'b1, 32'h00000001, 1);
    access(1'b1, 2'b11, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, 32'h00000001, 1);
    check("err_wr_cnt", wr_cnt - w0, 0);
    check("err_mem", mem[8], 32'h12AB5678);

    // Back-to-back: req held high, second request only taken after DONE.
    wait_ready();
    we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h30; wdata = 32'h11111111; req = 1'b1;
    x.e = 1'b0; x.rd = 32'h00000001; x.lat = 2; x.acc = cyc + 1;
    sb.push_back(x);
    @(posedge clk_dm);
    #1 addr = 32'h34; wdata = 32'h22222222;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_dm);
      if (done) break;
      check("b2b_busy_ready", {31'b0, ready}, 32'h0);
    end
    check("b2b_done_ready", {31'b0, ready}, 32'h0);
    x.acc = cyc + 2;
    sb.push_back(x);
    @(negedge clk_dm);
    check("b2b_ready_after", {31'b0, ready}, 32'h1);
    @(posedge clk_dm);
    #1 req = 1'b0;
    wait_idle();
    check("b2b_mem0", mem[12], 32'h11111111);
    check("b2b_mem1", mem[13], 32'h22222222);

    repeat (3) @(negedge clk_dm);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
